// File: rtl/mmc1_pkg.sv
// Shared types and constants for the MMC1 bank controller.
package mmc1_pkg;

    typedef enum logic [1:0] {
        MIR_ONE_LO = 2'd0,
        MIR_ONE_HI = 2'd1,
        MIR_VERT   = 2'd2,
        MIR_HORZ   = 2'd3
    } mirroring_e;

    typedef enum logic [1:0] {
        REG_CTRL = 2'd0,
        REG_CHR0 = 2'd1,
        REG_CHR1 = 2'd2,
        REG_PRG  = 2'd3
    } reg_sel_e;

    // PRG banking modes, encoded in control[3:2]
    localparam logic [1:0] PRG32_0       = 2'd0;
    localparam logic [1:0] PRG32_1       = 2'd1;
    localparam logic [1:0] PRG_FIX_FIRST = 2'd2;
    localparam logic [1:0] PRG_FIX_LAST  = 2'd3;

    localparam logic [4:0] CTRL_RST  = 5'h0C;
    localparam logic [4:0] SHIFT_RST = 5'h00;

    // Serial data arrives LSB first, so new bits enter at the top.
    function automatic logic [4:0] shift_in(input logic b, input logic [4:0] s);
        return {b, s[4:1]};
    endfunction

endpackage

// File: rtl/mmc1_serial_loader.sv
// Five-write serial loader: collects data[0] bits and emits a commit pulse.
// Build option MMC1_CONSEC_WR_IGNORE_EN drops a write that directly follows another.
module mmc1_serial_loader
    import mmc1_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_addr_hi,
    input  logic       i_data7,
    input  logic       i_data0,
    input  logic       i_wr_stb,
    input  logic       i_cycle_stb,
    output logic       o_commit,
    output logic       o_bit7_rst,
    output logic [4:0] o_value,
    output reg_sel_e   o_reg_sel
);

    logic [4:0] r_shift;
    logic [2:0] r_count;
    logic       w_qual;
    logic       w_accept;

    assign w_qual = i_wr_stb & i_addr_hi[2];

`ifdef MMC1_CONSEC_WR_IGNORE_EN
    logic r_prev_wr;

    // Read-modify-write instructions issue two writes on consecutive CPU cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_prev_wr <= 1'b0;
        else if (i_cycle_stb)
            r_prev_wr <= w_qual;
    end

    assign w_accept = w_qual & ~r_prev_wr;
`else
    logic w_unused_cycle;
    assign w_unused_cycle = i_cycle_stb;
    assign w_accept       = w_qual;
`endif

    assign o_value    = shift_in(i_data0, r_shift);
    assign o_reg_sel  = reg_sel_e'(i_addr_hi[1:0]);
    assign o_bit7_rst = w_accept & i_data7;
    assign o_commit   = w_accept & ~i_data7 & (r_count == 3'd4);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= SHIFT_RST;
            r_count <= 3'd0;
        end else if (w_accept) begin
            if (i_data7 || r_count == 3'd4) begin
                r_shift <= SHIFT_RST;
                r_count <= 3'd0;
            end else begin
                r_shift <= o_value;
                r_count <= r_count + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mmc1_mapper.sv
// MMC1-compatible bank controller: register file plus PRG/CHR address translation.
// Optional build macro: MMC1_CONSEC_WR_IGNORE_EN (consecutive-write suppression in the loader).
module mmc1_mapper
    import mmc1_pkg::*;
#(
    parameter  int PRG_BANKS = 16,
    parameter  int CHR_BANKS = 32,
    localparam int PRG_AW    = $clog2(PRG_BANKS) + 14,
    localparam int CHR_AW    = $clog2(CHR_BANKS) + 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [15:0]       i_cpu_addr,
    input  logic [7:0]        i_cpu_data_in,
    input  logic              i_cpu_wr_stb,
    input  logic              i_cpu_cycle_stb,
    input  logic [12:0]       i_ppu_addr,
    output logic [PRG_AW-1:0] o_prg_addr,
    output logic [CHR_AW-1:0] o_chr_addr,
    output logic              o_prg_ram_sel,
    output logic [1:0]        o_mirroring
);

    localparam int PB = $clog2(PRG_BANKS);
    localparam int CB = $clog2(CHR_BANKS);
    localparam logic [3:0] LAST_BANK = 4'(PRG_BANKS - 1);

    logic [4:0] r_ctrl;
    logic [4:0] r_chr0;
    logic [4:0] r_chr1;
    logic [4:0] r_prg;

    logic       w_commit;
    logic       w_bit7_rst;
    logic [4:0] w_value;
    reg_sel_e   w_reg_sel;
    logic [5:0] w_unused_data;
    logic [3:0] w_prg_bank;
    logic [4:0] w_chr_bank;
    mirroring_e w_mir;

    assign w_unused_data = i_cpu_data_in[6:1];

    mmc1_serial_loader u_loader (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_addr_hi   (i_cpu_addr[15:13]),
        .i_data7     (i_cpu_data_in[7]),
        .i_data0     (i_cpu_data_in[0]),
        .i_wr_stb    (i_cpu_wr_stb),
        .i_cycle_stb (i_cpu_cycle_stb),
        .o_commit    (w_commit),
        .o_bit7_rst  (w_bit7_rst),
        .o_value     (w_value),
        .o_reg_sel   (w_reg_sel)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl <= CTRL_RST;
            r_chr0 <= 5'd0;
            r_chr1 <= 5'd0;
            r_prg  <= 5'd0;
        end else if (w_bit7_rst) begin
            r_ctrl[3:2] <= PRG_FIX_LAST;
        end else if (w_commit) begin
            case (w_reg_sel)
                REG_CTRL: r_ctrl <= w_value;
                REG_CHR0: r_chr0 <= w_value;
                REG_CHR1: r_chr1 <= w_value;
                REG_PRG:  r_prg  <= w_value;
                default:  r_prg  <= r_prg;
            endcase
        end
    end

    always_comb begin
        w_prg_bank = 4'd0;
        case (r_ctrl[3:2])
            PRG32_0, PRG32_1: w_prg_bank = {r_prg[3:1], i_cpu_addr[14]};
            PRG_FIX_FIRST:    w_prg_bank = i_cpu_addr[14] ? r_prg[3:0] : 4'd0;
            PRG_FIX_LAST:     w_prg_bank = i_cpu_addr[14] ? LAST_BANK : r_prg[3:0];
            default:          w_prg_bank = 4'd0;
        endcase
    end

    // Bank numbers wrap to the populated size by dropping upper bits.
    assign o_prg_addr = {w_prg_bank[PB-1:0], i_cpu_addr[13:0]};

    assign w_chr_bank = r_ctrl[4] ? (i_ppu_addr[12] ? r_chr1 : r_chr0)
                                  : {r_chr0[4:1], i_ppu_addr[12]};
    assign o_chr_addr = {w_chr_bank[CB-1:0], i_ppu_addr[11:0]};

    assign o_prg_ram_sel = (i_cpu_addr[15:13] == 3'b011) & ~r_prg[4];

    assign w_mir       = mirroring_e'(r_ctrl[1:0]);
    assign o_mirroring = w_mir;

endmodule

// File: tb/tb_mmc1_mapper.sv
// Self-checking bench for mmc1_mapper: spec-level model checked every cycle plus literal spot checks.
module tb_mmc1_mapper;

    localparam int PRG_BANKS = 16;
    localparam int CHR_BANKS = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data = 8'h00;
    logic        wr_stb = 1'b0;
    logic        cyc_stb = 1'b0;
    logic [12:0] ppu_addr = 13'h0000;
    logic [17:0] prg_addr;
    logic [16:0] chr_addr;
    logic        ram_sel;
    logic [1:0]  mir;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int m_ctrl, m_chr0, m_chr1, m_prg;
    int m_bits[$];
    bit m_prev;

    mmc1_mapper #(.PRG_BANKS(PRG_BANKS), .CHR_BANKS(CHR_BANKS)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_cpu_addr      (cpu_addr),
        .i_cpu_data_in   (cpu_data),
        .i_cpu_wr_stb    (wr_stb),
        .i_cpu_cycle_stb (cyc_stb),
        .i_ppu_addr      (ppu_addr),
        .o_prg_addr      (prg_addr),
        .o_chr_addr      (chr_addr),
        .o_prg_ram_sel   (ram_sel),
        .o_mirroring     (mir)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0; m_prev = 1'b0;
        m_bits.delete();
    endfunction

    function automatic void m_step(input bit wr, input logic [15:0] a, input logic [7:0] d);
        bit qual;
        bit acc;
        int v;
        qual = wr && a[15];
        acc  = qual;
`ifdef MMC1_CONSEC_WR_IGNORE_EN
        acc    = qual && !m_prev;
        m_prev = qual;
`endif
        if (!acc) return;
        if (d[7]) begin
            m_bits.delete();
            m_ctrl = m_ctrl | 12;
            return;
        end
        m_bits.push_back(int'(d[0]));
        if (m_bits.size() == 5) begin
            v = 0;
            for (int i = 0; i < 5; i++) v += m_bits[i] * (1 << i);
            case (a[14:13])
                2'd0: m_ctrl = v;
                2'd1: m_chr0 = v;
                2'd2: m_chr1 = v;
                default: m_prg = v;
            endcase
            m_bits.delete();
        end
    endfunction

    function automatic int exp_prg(input logic [15:0] a);
        int mode, hi, bank;
        mode = (m_ctrl / 4) % 4;
        hi   = int'(a[14]);
        if (mode < 2)       bank = (m_prg % 16) / 2 * 2 + hi;
        else if (mode == 2) bank = hi ? (m_prg % 16) : 0;
        else                bank = hi ? (PRG_BANKS - 1) : (m_prg % 16);
        return (bank % PRG_BANKS) * 16384 + int'(a) % 16384;
    endfunction

    function automatic int exp_chr(input logic [12:0] p);
        int bank;
        if (m_ctrl < 16) bank = m_chr0 / 2 * 2 + int'(p[12]);
        else             bank = p[12] ? m_chr1 : m_chr0;
        return (bank % CHR_BANKS) * 4096 + int'(p) % 4096;
    endfunction

    function automatic int exp_ram(input logic [15:0] a);
        return (a >= 16'h6000 && a < 16'h8000 && m_prg < 16) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("prg_addr", 32'(prg_addr), exp_prg(cpu_addr));
                chk("chr_addr", 32'(chr_addr), exp_chr(ppu_addr));
                chk("prg_ram_sel", 32'(ram_sel), exp_ram(cpu_addr));
                chk("mirroring", 32'(mir), m_ctrl % 4);
            end
        end
    end

    // One CPU cycle = two clocks; strobes on the first. Entered at posedge+1.
    task automatic cyc(input bit wr, input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_data = d; wr_stb = wr; cyc_stb = 1'b1;
        @(posedge clk);
        m_step(wr, a, d);
        #1;
        wr_stb = 1'b0; cyc_stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr_sp(input logic [15:0] a, input logic [7:0] d);
        cyc(1'b1, a, d);
        cyc(1'b0, 16'h0000, 8'h00);
    endtask

    task automatic wr5(input logic [15:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) wr_sp(a, {7'b0, v[i]});
    endtask

    task automatic lit_prg(input string nm, input logic [15:0] a, input logic [31:0] e);
        cpu_addr = a; #3;
        chk(nm, 32'(prg_addr), e);
        @(posedge clk); #1;
    endtask

    task automatic lit_chr(input string nm, input logic [12:0] p, input logic [31:0] e);
        ppu_addr = p; #3;
        chk(nm, 32'(chr_addr), e);
        @(posedge clk); #1;
    endtask

    task automatic lit_ram(input string nm, input logic [15:0] a, input logic [31:0] e);
        cpu_addr = a; #3;
        chk(nm, 32'(ram_sel), e);
        @(posedge clk); #1;
    endtask

    task automatic lit_mir(input string nm, input logic [31:0] e);
        #3;
        chk(nm, 32'(mir), e);
        @(posedge clk); #1;
    endtask

    initial begin
        m_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        lit_prg("rst_prg_c123", 16'hC123, 32'h3C123);
        lit_prg("rst_prg_8000", 16'h8000, 32'h00000);
        lit_mir("rst_mir", 32'd0);
        lit_ram("rst_ram_6000", 16'h6000, 32'd1);
        lit_ram("rst_ram_5fff", 16'h5FFF, 32'd0);

        // PRG = 5 via $E000, with an ignored low-address write mid-sequence
        wr_sp(16'hE000, 8'h01);
        wr_sp(16'hE000, 8'h00);
        wr_sp(16'h6000, 8'h81);
        wr_sp(16'hE000, 8'h01);
        wr_sp(16'hE000, 8'h00);
        wr_sp(16'hE000, 8'h00);
        lit_prg("prg5_8456", 16'h8456, 32'h14456);
        lit_prg("prg5_c000", 16'hC000, 32'h3C000);

        // 32 KB mode, then bit-7 reset forces fix-last mode and drops partial bits
        wr5(16'h8000, 5'h00);
        lit_prg("p32_c000", 16'hC000, 32'h14000);
        lit_prg("p32_8000", 16'h8000, 32'h10000);
        for (int i = 0; i < 3; i++) wr_sp(16'h8000, 8'h01);
        wr_sp(16'h8000, 8'h80);
        lit_prg("b7_c000", 16'hC000, 32'h3C000);
        lit_prg("b7_8000", 16'h8000, 32'h14000);
        wr5(16'hA000, 5'h03);
        lit_chr("chr8k_1234", 13'h1234, 32'h03234);
        lit_chr("chr8k_0234", 13'h0234, 32'h02234);

        // 4 KB CHR mode, then back to 8 KB with odd chr0
        wr5(16'h8000, 5'h10);
        wr5(16'hA000, 5'h02);
        wr5(16'hC000, 5'h07);
        lit_chr("chr4k_0abc", 13'h0ABC, 32'h02ABC);
        lit_chr("chr4k_1abc", 13'h1ABC, 32'h07ABC);
        wr5(16'h8000, 5'h00);
        wr5(16'hA000, 5'h07);
        lit_chr("chr8k_1000", 13'h1000, 32'h07000);
        lit_chr("chr8k_0000", 13'h0000, 32'h06000);

        // Async reset in the middle of a serial sequence
        wr_sp(16'h8000, 8'h01);
        wr_sp(16'h8000, 8'h01);
        rst_n = 1'b0;
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wr5(16'h8000, 5'h02);
        lit_mir("rst_mid_mir", 32'd2);
        lit_ram("ram_en_6000", 16'h6000, 32'd1);
        lit_ram("ram_en_8000", 16'h8000, 32'd0);
        wr5(16'hE000, 5'h10);
        lit_ram("ram_dis_6000", 16'h6000, 32'd0);

        // Two writes on back-to-back CPU cycles, then spaced writes
        cyc(1'b1, 16'h8000, 8'h01);
        cyc(1'b1, 16'h8000, 8'h01);
        cyc(1'b0, 16'h0000, 8'h00);
        wr_sp(16'h8000, 8'h00);
        wr_sp(16'h8000, 8'h01);
        wr_sp(16'h8000, 8'h00);
`ifdef MMC1_CONSEC_WR_IGNORE_EN
        lit_mir("consec_pending", 32'd2);
        wr_sp(16'h8000, 8'h01);
        lit_mir("consec_commit", 32'd1);
`else
        lit_mir("consec_commit", 32'd3);
        wr_sp(16'h8000, 8'h01);
        lit_mir("consec_next", 32'd3);
`endif

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
